// File: rtl/mem_stage.sv
// Memory-access stage: issues data-memory loads/stores over a req/ready handshake,
// stalls the pipeline while an access is outstanding and registers the MEM/WB values.
//
// state  | meaning
// S_IDLE | nothing outstanding; request driven straight from the EX/MEM inputs
// S_WAIT | access outstanding; request driven from the latched op, timer running
module mem_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [3:0]  write_reg_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_byte,
    input  logic        mem_signed,
    input  logic        mem_to_reg_select,
    input  logic        reg_write_enable,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  write_reg_addr_out,
    output logic        mem_to_reg_select_out,
    output logic        reg_write_enable_out,
    output logic        align_fault,
    output logic        bus_error
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state, state_nxt;

    logic [31:0] lat_addr, lat_store_data;
    logic [3:0]  lat_reg;
    logic        lat_write, lat_byte, lat_signed, lat_m2r, lat_rwe;
    logic [7:0]  wait_tmr;

    logic [31:0] cur_addr, cur_store_data;
    logic [3:0]  cur_reg;
    logic        cur_write, cur_byte, cur_signed, cur_m2r, cur_rwe;
    logic        issue, pass, req, done, timeout;
    logic [7:0]  rbyte;
    logic [31:0] load_data;

    always_comb begin
        cur_addr       = alu_result;
        cur_store_data = store_data;
        cur_reg        = write_reg_addr;
        cur_write      = mem_write;
        cur_byte       = mem_byte;
        cur_signed     = mem_signed;
        cur_m2r        = mem_to_reg_select;
        cur_rwe        = reg_write_enable;
        if (state == S_WAIT) begin
            cur_addr       = lat_addr;
            cur_store_data = lat_store_data;
            cur_reg        = lat_reg;
            cur_write      = lat_write;
            cur_byte       = lat_byte;
            cur_signed     = lat_signed;
            cur_m2r        = lat_m2r;
            cur_rwe        = lat_rwe;
        end

        issue   = (state == S_IDLE) && in_valid && (mem_read || mem_write);
        pass    = (state == S_IDLE) && in_valid && !mem_read && !mem_write;
        req     = !reset && (issue || (state == S_WAIT));
        done    = req && dmem_ready;
        // ready on the last permitted cycle still wins over the abort
        timeout = !reset && (state == S_WAIT) && !dmem_ready && (wait_tmr == 8'd0);

        state_nxt = state;
        if ((state == S_IDLE) && issue && !dmem_ready)
            state_nxt = S_WAIT;
        else if ((state == S_WAIT) && (dmem_ready || timeout))
            state_nxt = S_IDLE;

        dmem_req    = req;
        dmem_we     = req && cur_write;
        dmem_addr   = {cur_addr[31:2], 2'b00};
        dmem_be     = cur_byte ? (4'b0001 << cur_addr[1:0]) : 4'b1111;
        dmem_wdata  = cur_byte ? {4{cur_store_data[7:0]}} : cur_store_data;
        stall       = req && !dmem_ready && !timeout;
        align_fault = !reset && issue && !mem_byte && (alu_result[1:0] != 2'b00);
        bus_error   = timeout;

        case (cur_addr[1:0])
            2'd0:    rbyte = dmem_rdata[7:0];
            2'd1:    rbyte = dmem_rdata[15:8];
            2'd2:    rbyte = dmem_rdata[23:16];
            default: rbyte = dmem_rdata[31:24];
        endcase
        load_data = cur_byte ? {{24{cur_signed & rbyte[7]}}, rbyte} : dmem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr              <= '0;
            lat_store_data        <= '0;
            lat_reg               <= '0;
            lat_write             <= 1'b0;
            lat_byte              <= 1'b0;
            lat_signed            <= 1'b0;
            lat_m2r               <= 1'b0;
            lat_rwe               <= 1'b0;
            wait_tmr              <= '0;
            alu_result_out        <= '0;
            mem_data_out          <= '0;
            write_reg_addr_out    <= '0;
            mem_to_reg_select_out <= 1'b0;
            reg_write_enable_out  <= 1'b0;
        end else begin
            if (issue) begin
                lat_addr       <= alu_result;
                lat_store_data <= store_data;
                lat_reg        <= write_reg_addr;
                lat_write      <= mem_write;
                lat_byte       <= mem_byte;
                lat_signed     <= mem_signed;
                lat_m2r        <= mem_to_reg_select;
                lat_rwe        <= reg_write_enable;
            end

            // down-counter: terminal count 0 marks the last permitted WAIT cycle
            if (issue && !dmem_ready)
                wait_tmr <= 8'(MAX_WAIT - 1);
            else if ((state == S_WAIT) && (wait_tmr != 8'd0))
                wait_tmr <= wait_tmr - 8'd1;

            alu_result_out        <= '0;
            mem_data_out          <= '0;
            write_reg_addr_out    <= '0;
            mem_to_reg_select_out <= 1'b0;
            reg_write_enable_out  <= 1'b0;
            if (pass) begin
                alu_result_out        <= alu_result;
                write_reg_addr_out    <= write_reg_addr;
                mem_to_reg_select_out <= mem_to_reg_select;
                reg_write_enable_out  <= reg_write_enable;
            end else if (done) begin
                alu_result_out        <= cur_addr;
                mem_data_out          <= cur_write ? 32'd0 : load_data;
                write_reg_addr_out    <= cur_reg;
                mem_to_reg_select_out <= cur_m2r;
                reg_write_enable_out  <= cur_rwe;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: fixed vectors, hand-written multi-cycle sequences and
// randomized accesses checked against an arithmetic reference model.
module tb_mem_stage;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] alu_result, store_data;
    logic [3:0]  write_reg_addr;
    logic        mem_read, mem_write, mem_byte, mem_signed;
    logic        mem_to_reg_select, reg_write_enable;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] alu_result_out, mem_data_out;
    logic [3:0]  write_reg_addr_out;
    logic        mem_to_reg_select_out, reg_write_enable_out;
    logic        align_fault, bus_error;

    mem_stage #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .alu_result(alu_result),
        .store_data(store_data), .write_reg_addr(write_reg_addr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte(mem_byte),
        .mem_signed(mem_signed), .mem_to_reg_select(mem_to_reg_select),
        .reg_write_enable(reg_write_enable), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall(stall),
        .alu_result_out(alu_result_out), .mem_data_out(mem_data_out),
        .write_reg_addr_out(write_reg_addr_out),
        .mem_to_reg_select_out(mem_to_reg_select_out),
        .reg_write_enable_out(reg_write_enable_out),
        .align_fault(align_fault), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_wb(input string name, input logic [31:0] alu, input logic [31:0] md,
                          input logic [3:0] wreg, input logic m2r, input logic rwe);
        chk({name, "_alu"},  alu_result_out, alu);
        chk({name, "_mdat"}, mem_data_out, md);
        chk({name, "_wreg"}, 32'(write_reg_addr_out), 32'(wreg));
        chk({name, "_m2r"},  32'(mem_to_reg_select_out), 32'(m2r));
        chk({name, "_rwe"},  32'(reg_write_enable_out), 32'(rwe));
    endtask

    // reference: pick the addressed lane, extend arithmetically
    function automatic logic [31:0] load_val(input logic [31:0] addr, input logic [31:0] rdata,
                                             input logic byt, input logic sgn);
        int v;
        if (!byt) return rdata;
        v = int'((rdata >> (8 * int'(addr % 4))) % 256);
        if (sgn && v >= 128) v = v - 256;
        return 32'(v);
    endfunction

    task automatic set_idle();
        in_valid = 1'b0; alu_result = '0; store_data = '0; write_reg_addr = '0;
        mem_read = 1'b0; mem_write = 1'b0; mem_byte = 1'b0; mem_signed = 1'b0;
        mem_to_reg_select = 1'b0; reg_write_enable = 1'b0;
        dmem_ready = 1'b0; dmem_rdata = '0;
    endtask

    task automatic scramble();
        in_valid = 1'($urandom); alu_result = $urandom; store_data = $urandom;
        write_reg_addr = 4'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
        mem_byte = 1'($urandom); mem_signed = 1'($urandom);
        mem_to_reg_select = 1'($urandom); reg_write_enable = 1'($urandom);
    endtask

    // lat = cycle index (issue cycle = 0) at which ready is given; > MW never arrives
    task automatic do_access(input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                             input logic [3:0] wreg, input logic rd, input logic wr,
                             input logic byt, input logic sgn, input logic m2r,
                             input logic rwe, input int lat);
        bit          ok;
        int          last, nstall;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        ok      = (lat <= MW);
        last    = ok ? lat : MW;
        nstall  = 0;
        e_wdata = byt ? 32'(a[7:0] * 0 + sd[7:0]) * 32'h0101_0101 : sd;
        e_be    = byt ? 4'(1 << int'(a % 4)) : 4'hF;
        in_valid = 1'b1; alu_result = a; store_data = sd; write_reg_addr = wreg;
        mem_read = rd; mem_write = wr; mem_byte = byt; mem_signed = sgn;
        mem_to_reg_select = m2r; reg_write_enable = rwe;
        for (int i = 0; i <= last; i++) begin
            if (i > 0) scramble();
            dmem_ready = (i == lat);
            dmem_rdata = (i == lat) ? rdata : $urandom;
            @(negedge clk);
            chk("acc_req",    32'(dmem_req), 32'd1);
            chk("acc_we",     32'(dmem_we), 32'(wr));
            chk("acc_addr",   dmem_addr, a & 32'hFFFF_FFFC);
            chk("acc_be",     32'(dmem_be), 32'(e_be));
            chk("acc_wdata",  dmem_wdata, e_wdata);
            chk("acc_stall",  32'(stall), 32'(i != last));
            chk("acc_align",  32'(align_fault), 32'(i == 0 && !byt && (a % 4) != 0));
            chk("acc_buserr", 32'(bus_error), 32'(!ok && i == MW));
            if (stall) nstall++;
            @(posedge clk); #1;
            if (i < last) chk_wb("acc_bubble", 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        end
        chk("acc_stall_cycles", 32'(nstall), 32'(last));
        if (ok) chk_wb("acc_wb", a, wr ? 32'd0 : load_val(a, rdata, byt, sgn), wreg, m2r, rwe);
        else    chk_wb("acc_abort", 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        dmem_ready = 1'b0;
    endtask

    typedef struct {
        logic iv; logic [31:0] alu; logic [31:0] sd; logic [3:0] wreg;
        logic rd; logic wr; logic byt; logic sgn; logic m2r; logic rwe;
        logic rdy; logic [31:0] rdata;
        logic e_req; logic e_we; logic [31:0] e_addr; logic [31:0] e_wdata;
        logic [3:0] e_be; logic e_al;
        logic [31:0] e_alu; logic [31:0] e_md; logic [3:0] e_wreg; logic e_m2r; logic e_rwe;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1, 32'h1234, 32'h0, 4'd5, 0,0,0,0, 0,1, 0, 32'h0,
                    0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h1234, 32'h0, 4'd5, 0, 1};
        vecs[1] = '{1, 32'h100, 32'h1111_2222, 4'd3, 1,0,0,0, 1,1, 1, 32'hDEAD_BEEF,
                    1, 0, 32'h100, 32'h1111_2222, 4'hF, 0, 32'h100, 32'hDEAD_BEEF, 4'd3, 1, 1};
        vecs[2] = '{1, 32'h41, 32'h0000_00AB, 4'd0, 0,1,1,0, 0,0, 1, 32'h0,
                    1, 1, 32'h40, 32'hABAB_ABAB, 4'b0010, 0, 32'h41, 32'h0, 4'd0, 0, 0};
        vecs[3] = '{1, 32'h1002, 32'h0, 4'd9, 1,0,1,0, 1,1, 1, 32'h12F4_5678,
                    1, 0, 32'h1000, 32'h0, 4'b0100, 0, 32'h1002, 32'h0000_00F4, 4'd9, 1, 1};
        vecs[4] = '{1, 32'h1003, 32'h0, 4'd10, 1,0,1,1, 1,1, 1, 32'h9A00_0000,
                    1, 0, 32'h1000, 32'h0, 4'b1000, 0, 32'h1003, 32'hFFFF_FF9A, 4'd10, 1, 1};
        vecs[5] = '{1, 32'h2000, 32'h0, 4'd11, 1,0,1,1, 1,1, 1, 32'h0000_007F,
                    1, 0, 32'h2000, 32'h0, 4'b0001, 0, 32'h2000, 32'h0000_007F, 4'd11, 1, 1};
        vecs[6] = '{1, 32'h306, 32'h0, 4'd12, 1,0,0,0, 1,1, 1, 32'hCAFE_F00D,
                    1, 0, 32'h304, 32'h0, 4'hF, 1, 32'h306, 32'hCAFE_F00D, 4'd12, 1, 1};
        vecs[7] = '{1, 32'h500, 32'h55AA_55AA, 4'd7, 1,1,0,0, 0,1, 1, 32'h1234_5678,
                    1, 1, 32'h500, 32'h55AA_55AA, 4'hF, 0, 32'h500, 32'h0, 4'd7, 0, 1};
        vecs[8] = '{0, 32'h600, 32'h0, 4'd2, 1,0,0,0, 1,1, 1, 32'h1,
                    0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 32'h0, 4'd0, 0, 0};
        vecs[9] = '{1, 32'h7, 32'h0102_0304, 4'd1, 0,1,0,0, 0,1, 1, 32'h0,
                    1, 1, 32'h4, 32'h0102_0304, 4'hF, 1, 32'h7, 32'h0, 4'd1, 0, 1};

        // reset state, with a live load on the inputs that must not reach the bus
        set_idle();
        reset = 1'b1; in_valid = 1'b1; mem_read = 1'b1;
        #3;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_align", 32'(align_fault), 32'd0);
        chk("rst_buserr", 32'(bus_error), 32'd0);
        chk_wb("rst", 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_wb("rst_edge", 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        set_idle();

        for (int v = 0; v < 10; v++) begin
            in_valid = vecs[v].iv; alu_result = vecs[v].alu; store_data = vecs[v].sd;
            write_reg_addr = vecs[v].wreg; mem_read = vecs[v].rd; mem_write = vecs[v].wr;
            mem_byte = vecs[v].byt; mem_signed = vecs[v].sgn;
            mem_to_reg_select = vecs[v].m2r; reg_write_enable = vecs[v].rwe;
            dmem_ready = vecs[v].rdy; dmem_rdata = vecs[v].rdata;
            @(negedge clk);
            chk("vec_req", 32'(dmem_req), 32'(vecs[v].e_req));
            chk("vec_stall", 32'(stall), 32'd0);
            chk("vec_align", 32'(align_fault), 32'(vecs[v].e_al));
            if (vecs[v].e_req) begin
                chk("vec_we", 32'(dmem_we), 32'(vecs[v].e_we));
                chk("vec_addr", dmem_addr, vecs[v].e_addr);
                chk("vec_be", 32'(dmem_be), 32'(vecs[v].e_be));
                chk("vec_wdata", dmem_wdata, vecs[v].e_wdata);
            end
            @(posedge clk); #1;
            chk_wb("vec_wb", vecs[v].e_alu, vecs[v].e_md, vecs[v].e_wreg,
                   vecs[v].e_m2r, vecs[v].e_rwe);
        end
        set_idle();

        // reset while a word load is outstanding
        in_valid = 1'b1; alu_result = 32'h80; mem_read = 1'b1; write_reg_addr = 4'd4;
        mem_to_reg_select = 1'b1; reg_write_enable = 1'b1;
        @(posedge clk); #1;
        alu_result = 32'hF00;
        @(negedge clk);
        chk("rw_wait_req", 32'(dmem_req), 32'd1);
        chk("rw_wait_stall", 32'(stall), 32'd1);
        chk("rw_wait_addr", dmem_addr, 32'h80);
        #2 reset = 1'b1;
        #1;
        chk("rw_req", 32'(dmem_req), 32'd0);
        chk("rw_stall", 32'(stall), 32'd0);
        chk_wb("rw", 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        alu_result = 32'h90; write_reg_addr = 4'd6; dmem_ready = 1'b1; dmem_rdata = 32'h1111;
        @(negedge clk);
        chk("rw_next_req", 32'(dmem_req), 32'd1);
        chk("rw_next_addr", dmem_addr, 32'h90);
        chk("rw_next_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk_wb("rw_next", 32'h90, 32'h1111, 4'd6, 1'b1, 1'b1);
        set_idle();

        // signed byte load, three stall cycles
        do_access(32'h203, 32'h0, 32'h80FF_0000, 4'd8, 1, 0, 1, 1, 1, 1, 3);
        set_idle();
        // timeout, then a normal access to show the FSM is back in IDLE
        do_access(32'h400, 32'h0, 32'h0, 4'd2, 1, 0, 0, 0, 1, 1, MW + 1);
        set_idle();
        do_access(32'h404, 32'h0, 32'h0BAD_F00D, 4'd3, 1, 0, 0, 0, 1, 1, 0);
        set_idle();
        // ready on the last permitted cycle completes instead of aborting
        do_access(32'h408, 32'h0, 32'h7777_0001, 4'd1, 1, 0, 0, 0, 1, 1, MW);
        set_idle();

        for (int t = 0; t < 250; t++) begin
            int k;
            k = int'($urandom_range(0, 4));
            if (k == 0) begin
                scramble();
                in_valid = 1'b0;
                dmem_ready = 1'($urandom); dmem_rdata = $urandom;
                @(negedge clk);
                chk("idle_req", 32'(dmem_req), 32'd0);
                chk("idle_stall", 32'(stall), 32'd0);
                @(posedge clk); #1;
                chk_wb("idle", 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
            end else if (k == 1) begin
                logic [31:0] a;
                scramble();
                a = alu_result;
                in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
                dmem_ready = 1'($urandom);
                @(negedge clk);
                chk("pass_req", 32'(dmem_req), 32'd0);
                chk("pass_stall", 32'(stall), 32'd0);
                @(posedge clk); #1;
                chk_wb("pass", a, 32'd0, write_reg_addr, mem_to_reg_select, reg_write_enable);
            end else begin
                do_access($urandom, $urandom, $urandom, 4'($urandom),
                          (k != 3), (k != 2), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), int'($urandom_range(0, MW + 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the 5-stage ARM pipeline, between the EX/MEM latch and the write-back stage. It issues loads and stores to the data-memory port with a req/ready handshake and stalls the pipeline while an access is outstanding. It extracts and extends byte loads and registers the MEM/WB pipeline values that feed write-back's ALU-vs-memory select mux.

Parameters:
MAX_WAIT, 16, maximum cycles in WAIT before the access is aborted with bus_error; legal range 1..255.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  EX/MEM holds a valid instruction
alu_result  input  32  ALU result; also the memory address
store_data  input  32  register data for stores
write_reg_addr  input  4  destination register
mem_read  input  1  load
mem_write  input  1  store
mem_byte  input  1  1 = byte access, 0 = word access
mem_signed  input  1  sign-extend byte loads
mem_to_reg_select  input  1  forwarded to WB
reg_write_enable  input  1  forwarded to WB
dmem_req  output  1  memory request
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address ([1:0] always 00)
dmem_wdata  output  32  write data
dmem_be  output  4  byte enables
dmem_ready  input  1  memory completes the request this cycle
dmem_rdata  input  32  read data, valid when dmem_ready=1
stall  output  1  freeze IF/ID/EX and the EX/MEM latch
alu_result_out  output  32  registered to WB
mem_data_out  output  32  registered, extended load data
write_reg_addr_out  output  4  registered to WB
mem_to_reg_select_out  output  1  registered to WB
reg_write_enable_out  output  1  registered to WB
align_fault  output  1  one-cycle pulse: misaligned word access
bus_error  output  1  one-cycle pulse: access timed out

Behaviour:
- Reset (asynchronous): state IDLE, wait counter 0. Every registered output is 0. dmem_req, stall, align_fault and bus_error are 0 while reset is high.
- FSM states are IDLE and WAIT.
- IDLE, in_valid=1, mem_read=0 and mem_write=0: no request. Inputs are registered to the WB outputs on the next edge (1-cycle latency). mem_data_out = 0.
- IDLE, in_valid=1 with mem_read or mem_write:
  - Same cycle: dmem_req=1, driven combinationally from the inputs; the op is latched at the edge.
  - dmem_ready=1 in the same cycle: access completes, WB outputs load, stay IDLE, stall=0.
  - dmem_ready=0: go to WAIT.
  - stall = dmem_req & ~dmem_ready.
- WAIT:
  - Request signals are driven from the latched copy, so input changes are ignored. dmem_req=1 and stall=1 every cycle until completion.
  - On dmem_ready=1: complete, WB outputs load from the latch plus dmem_rdata, return to IDLE. stall=0 that cycle.
  - Counter increments each WAIT cycle. On the cycle it reaches MAX_WAIT without ready: abort, bus_error pulses, WB bubble, return to IDLE, stall=0.
- If mem_read and mem_write are both 1, the access is treated as a store.
- When no access completes (in_valid=0, stall, or abort), the WB outputs take a bubble: reg_write_enable_out=0, all other registered outputs 0.
- Addressing:
  - Little-endian. dmem_addr = {addr[31:2], 2'b00}.
  - Word: dmem_be = 1111, wdata = store_data.
  - Byte: dmem_be = 0001 << addr[1:0], wdata = store_data[7:0] replicated into all four lanes.
- Byte load: select the rdata lane given by addr[1:0]. Zero-extend, or sign-extend from bit 7 when mem_signed=1.
- Misaligned word (addr[1:0] != 00): align_fault pulses in the issue cycle. The access proceeds at the forced-aligned address and the load result is unrotated.
- Store completion: reg_write_enable_out follows the latched reg_write_enable.
- dmem_ready while no request is outstanding is ignored.
- Reset during WAIT: dmem_req drops immediately, the access is discarded, FSM returns to IDLE.

Test Plan:
- Reset mid-WAIT: word load outstanding, assert reset -> dmem_req=0 asynchronously, all outputs 0, state IDLE; next load after release issues normally.
- Pass-through: in_valid=1, alu_result=0x0000_1234, write_reg_addr=5, reg_write_enable=1, no mem op -> next cycle alu_result_out=0x1234, write_reg_addr_out=5, reg_write_enable_out=1, mem_data_out=0, dmem_req never 1.
- Zero-wait word load: addr 0x100, dmem_ready=1 in the same cycle, rdata=0xDEADBEEF -> stall stays 0; next cycle mem_data_out=0xDEADBEEF, mem_to_reg_select_out=1.
- Signed byte load with 3 wait cycles: addr 0x203, rdata=0x80FF_0000 -> dmem_addr=0x200, stall=1 for 3 cycles, WB bubble each stall cycle, then mem_data_out=0xFFFF_FF80.
- Byte store: addr 0x41, store_data=0x0000_00AB -> dmem_we=1, dmem_be=0010, dmem_wdata=0xABABABAB.
- Timeout: MAX_WAIT=4, dmem_ready held 0 -> stall=1 for 4 cycles, bus_error pulses once, reg_write_enable_out=0, FSM back to IDLE.
